// File: rtl/periph_reg_arbiter_if.sv
// Register-bus types and the bundle of initiator/target request-response signals
// that the peripheral arbiter sits between.
package reg_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;
endpackage

interface periph_reg_arbiter_if #(
  parameter int unsigned NumPorts = 2,
  parameter type         req_t    = reg_pkg::reg_req_t,
  parameter type         rsp_t    = reg_pkg::reg_rsp_t
);
  req_t [NumPorts-1:0] in_req;
  rsp_t [NumPorts-1:0] in_rsp;
  req_t                out_req;
  rsp_t                out_rsp;

  // slave is the arbiter's view; master is the initiators-plus-target side.
  modport slave  (input  in_req, out_rsp, output in_rsp, out_req);
  modport master (output in_req, out_rsp, input  in_rsp, out_req);
endinterface

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NumPorts initiators,
// with the grant locked per transaction and a watchdog that aborts hung accesses.
module periph_reg_arbiter #(
  parameter int unsigned  NumPorts      = 2,
  parameter int unsigned  TimeoutCycles = 256,
  parameter type          req_t         = reg_pkg::reg_req_t,
  parameter type          rsp_t         = reg_pkg::reg_rsp_t,
  localparam int unsigned IdxW          = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  periph_reg_arbiter_if.slave        bus,
  output logic                       busy_o,
  output logic [IdxW-1:0]            grant_idx_o,
  output logic                       timeout_o
);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef logic [IdxW-1:0] idx_t;

  state_e            state_q, state_d;
  idx_t              rr_ptr_q, rr_ptr_d;
  idx_t              grant_q, grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  idx_t              pick_idx, cand, next_ptr;
  logic              pick_vld;
  req_t              out_req;
  rsp_t [NumPorts-1:0] in_rsp;

  // Highest-priority valid port starting at rr_ptr; scanned backwards so the
  // last write is the closest candidate.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = '0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      cand = idx_t'((int'(rr_ptr_q) + i) % int'(NumPorts));
      if (bus.in_req[cand].valid) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign next_ptr = (grant_q == idx_t'(NumPorts - 1)) ? '0 : grant_q + idx_t'(1);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    out_req   = '0;
    in_rsp    = '0;
    busy_o    = 1'b0;
    timeout_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_o  = 1'b1;
        out_req = bus.in_req[grant_q];
        if (!bus.in_req[grant_q].valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (bus.out_rsp.ready) begin
          in_rsp[grant_q] = bus.out_rsp;
          state_d         = IDLE;
          rr_ptr_d        = next_ptr;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          in_rsp[grant_q].ready = 1'b1;
          in_rsp[grant_q].error = 1'b1;
          timeout_o             = 1'b1;
          state_d               = IDLE;
          rr_ptr_d              = next_ptr;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A transaction caught by reset is dropped without any response.
    if (rst_i) begin
      in_rsp    = '0;
      timeout_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out_req  = out_req;
  assign bus.in_rsp   = in_rsp;
  assign grant_idx_o  = grant_q;
endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Bench for periph_reg_arbiter: directed cycle table, round-robin and watchdog-off
// sequences on a 3-port instance, and randomized traffic against a transaction model.
module tb_periph_reg_arbiter;
  import reg_pkg::*;

  localparam logic [31:0] A0 = 32'h2000_0020;
  localparam logic [31:0] A1 = 32'h2000_0010;

  logic       clk = 1'b0;
  logic       rst2, rst3;
  logic       busy2, to2, busy3, to3;
  logic [0:0] gnt2;
  logic [1:0] gnt3;

  always #5 clk = ~clk;

  periph_reg_arbiter_if #(.NumPorts(2)) if2 ();
  periph_reg_arbiter_if #(.NumPorts(3)) if3 ();

  periph_reg_arbiter #(.NumPorts(2), .TimeoutCycles(8)) dut2 (
    .clk_i(clk), .rst_i(rst2), .bus(if2),
    .busy_o(busy2), .grant_idx_o(gnt2), .timeout_o(to2)
  );

  periph_reg_arbiter #(.NumPorts(3), .TimeoutCycles(0)) dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(if3),
    .busy_o(busy3), .grant_idx_o(gnt3), .timeout_o(to3)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic        ready;
    logic        error;
    logic [31:0] rdata;
    logic        e_busy;
    logic        e_oval;
    logic [31:0] e_oaddr;
    logic [1:0]  e_rdy;
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    logic        e_to;
    logic        e_gnt;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] valid, input logic ready,
                              input logic error, input logic [31:0] rdata, input logic eb,
                              input logic eov, input logic [31:0] ea, input logic [1:0] erdy,
                              input logic [1:0] eerr, input logic [31:0] erd, input logic eto,
                              input logic eg);
    vec_t v;
    v.rst = rst; v.valid = valid; v.ready = ready; v.error = error; v.rdata = rdata;
    v.e_busy = eb; v.e_oval = eov; v.e_oaddr = ea; v.e_rdy = erdy; v.e_err = eerr;
    v.e_rdata = erd; v.e_to = eto; v.e_gnt = eg;
    return v;
  endfunction

  task automatic drive2(input vec_t v);
    reg_req_t r;
    reg_rsp_t s;
    rst2 = v.rst;
    for (int k = 0; k < 2; k++) begin
      r.valid = v.valid[k];
      r.write = (k == 0);
      r.addr  = (k == 0) ? A0 : A1;
      r.wdata = 32'h1111_0000 + 32'(k);
      r.wstrb = 4'hf;
      if2.in_req[k] = r;
    end
    s.ready = v.ready; s.error = v.error; s.rdata = v.rdata;
    if2.out_rsp = s;
  endtask

  vec_t           vq[$];
  reg_req_t       rq[2];
  reg_rsp_t       rs;
  reg_req_t       exp_out;
  reg_rsp_t [1:0] exp_rsp2;
  reg_rsp_t [2:0] exp_rsp3;
  reg_req_t       r3;
  logic           exp_to, rnd_rst;

  // Transaction-level model of the 2-port instance.
  bit m_busy;
  int m_grant, m_next, m_age;

  initial begin
    vec_t v;
    reg_rsp_t er;
    int bad;

    rst2 = 1'b1; rst3 = 1'b1;
    if2.in_req = '0; if2.out_rsp = '0;
    if3.in_req = '0; if3.out_rsp = '0;
    repeat (2) @(posedge clk);
    #1;

    // ---------------- directed cycle table on the 2-port instance ----------------
    vq.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 0, 0, 1, 1, A1, 2'b00, 2'b00, 0, 0, 1));
    vq.push_back(mk(0, 2'b10, 1, 0, 32'h1234_5678, 1, 1, A1, 2'b10, 2'b00, 32'h1234_5678, 0, 1));
    vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1));
    vq.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1));
    for (int i = 0; i < 7; i++)
      vq.push_back(mk(0, 2'b01, 0, 0, 0, 1, 1, A0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 0, 0, 0, 1, 1, A0, 2'b01, 2'b01, 0, 1, 0));
    vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    for (int i = 0; i < 7; i++)
      vq.push_back(mk(0, 2'b01, 0, 0, 0, 1, 1, A0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b01, 1, 1, 32'hCAFE_0001, 1, 1, A0, 2'b01, 2'b01, 32'hCAFE_0001, 0, 0));
    vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 0, 0, 1, 1, A1, 2'b00, 2'b00, 0, 0, 1));
    vq.push_back(mk(0, 2'b10, 0, 0, 0, 1, 1, A1, 2'b00, 2'b00, 0, 0, 1));
    vq.push_back(mk(1, 2'b10, 1, 0, 32'hDEAD_BEEF, 1, 1, A1, 2'b00, 2'b00, 0, 0, 1));
    vq.push_back(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 1, A0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 1, 0, 32'h5555_AAAA, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    vq.push_back(mk(0, 2'b10, 1, 0, 32'hA5A5_0033, 1, 1, A1, 2'b10, 2'b00, 32'hA5A5_0033, 0, 1));
    vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive2(v);
      #1;
      check($sformatf("row%0d busy", i), 128'(busy2), 128'(v.e_busy));
      check($sformatf("row%0d out_valid", i), 128'(if2.out_req.valid), 128'(v.e_oval));
      if (v.e_oval) check($sformatf("row%0d out_addr", i), 128'(if2.out_req.addr), 128'(v.e_oaddr));
      for (int k = 0; k < 2; k++) begin
        er.ready = v.e_rdy[k];
        er.error = v.e_err[k];
        er.rdata = v.e_rdy[k] ? v.e_rdata : 32'h0;
        check($sformatf("row%0d rsp%0d", i, k), 128'(if2.in_rsp[k]), 128'(er));
      end
      check($sformatf("row%0d timeout", i), 128'(to2), 128'(v.e_to));
      check($sformatf("row%0d grant", i), 128'(gnt2), 128'(v.e_gnt));
      @(posedge clk);
      #1;
    end

    // ---------------- 3-port round robin, all ports always valid ----------------
    rst3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r3.valid = 1'b1; r3.write = 1'b0; r3.addr = 32'h3000_0000 + 32'(4 * k);
      r3.wdata = '0; r3.wstrb = 4'h0;
      if3.in_req[k] = r3;
    end
    rs.ready = 1'b1; rs.error = 1'b0; rs.rdata = 32'hB000_0000;
    if3.out_rsp = rs;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_rsp3 = '0;
      check($sformatf("rr c%0d busy", c), 128'(busy3), 128'(c % 2));
      if (c % 2 == 1) begin
        exp_rsp3[(c / 2) % 3] = rs;
        check($sformatf("rr c%0d grant", c), 128'(gnt3), 128'((c / 2) % 3));
        check($sformatf("rr c%0d addr", c), 128'(if3.out_req.addr), 128'(32'h3000_0000 + 32'(4 * ((c / 2) % 3))));
      end
      check($sformatf("rr c%0d rsp", c), 128'(if3.in_rsp), 128'(exp_rsp3));
      @(posedge clk);
      #1;
    end

    // ---------------- watchdog disabled: a long stall never aborts ----------------
    rs.ready = 1'b0;
    if3.out_rsp = rs;
    @(posedge clk);
    #1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (to3 !== 1'b0 || busy3 !== 1'b1 || if3.in_rsp !== '0) bad++;
      @(posedge clk);
      #1;
    end
    check("wd_off stall cycles with abort or idle", 128'(bad), 128'(0));
    check("wd_off grant", 128'(gnt3), 128'(2));
    rs.ready = 1'b1; rs.rdata = 32'h0000_0300;
    if3.out_rsp = rs;
    #1;
    exp_rsp3 = '0;
    exp_rsp3[2] = rs;
    check("wd_off late completion", 128'(if3.in_rsp), 128'(exp_rsp3));
    @(posedge clk);
    #1;
    if3.in_req = '0;

    // ---------------- randomized traffic on the 2-port instance ----------------
    rst2 = 1'b1;
    if2.in_req = '0; if2.out_rsp = '0;
    @(posedge clk);
    #1;
    m_busy = 0; m_grant = 0; m_next = 0; m_age = 0;
    for (int c = 0; c < 800; c++) begin
      bit found;
      rnd_rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        if (m_busy && k == m_grant) rq[k].valid = ($urandom_range(0, 19) != 0);
        else                        rq[k].valid = 1'($urandom_range(0, 1));
        rq[k].write = 1'($urandom_range(0, 1));
        rq[k].addr  = $urandom;
        rq[k].wdata = $urandom;
        rq[k].wstrb = 4'($urandom_range(0, 15));
        if2.in_req[k] = rq[k];
      end
      rs.ready = ($urandom_range(0, 11) == 0);
      rs.error = 1'($urandom_range(0, 1));
      rs.rdata = $urandom;
      if2.out_rsp = rs;
      rst2 = rnd_rst;
      #1;

      exp_out  = m_busy ? rq[m_grant] : '0;
      exp_rsp2 = '0;
      exp_to   = 1'b0;
      if (m_busy && !rnd_rst && rq[m_grant].valid) begin
        if (rs.ready) exp_rsp2[m_grant] = rs;
        else if (m_age == 7) begin
          exp_rsp2[m_grant].ready = 1'b1;
          exp_rsp2[m_grant].error = 1'b1;
          exp_to = 1'b1;
        end
      end
      check($sformatf("rnd%0d busy", c), 128'(busy2), 128'(m_busy));
      check($sformatf("rnd%0d out_req", c), 128'(if2.out_req), 128'(exp_out));
      check($sformatf("rnd%0d rsp", c), 128'(if2.in_rsp), 128'(exp_rsp2));
      check($sformatf("rnd%0d timeout", c), 128'(to2), 128'(exp_to));
      check($sformatf("rnd%0d grant", c), 128'(gnt2), 128'(m_grant));

      if (rnd_rst) begin
        m_busy = 0; m_grant = 0; m_next = 0; m_age = 0;
      end else if (!m_busy) begin
        found = 0;
        for (int s = 0; s < 2; s++) begin
          if (!found && rq[(m_next + s) % 2].valid) begin
            found = 1; m_busy = 1; m_grant = (m_next + s) % 2; m_age = 0;
          end
        end
      end else if (!rq[m_grant].valid || rs.ready || m_age == 7) begin
        m_busy = 0;
        m_next = (m_grant + 1) % 2;
      end else begin
        m_age++;
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
